picosoc_bus_arbiter: RTL and testbench
======================================

Name: picosoc_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets the CPU (master 0) and a DMA/framebuffer fetch engine (master 1) share the on-chip RAM and peripheral decode without modifying either master.
- Arbitration is round-robin with a registered grant. The slave side is a combinational pass-through of the granted master.
- An optional watchdog completes hung transfers.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in GRANT without s_ready before a forced completion. Only used with the optional feature. Legal range 1..65535.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on a forced completion.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_valid  input  1  master 0 request; held high until m0_ready
- m0_ready  output  1  master 0 transfer complete, single-cycle pulse
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 byte enables; 0 = read
- m0_rdata  output  32  master 0 read data, valid while m0_ready
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as master 0, for master 1
- s_valid  output  1  slave request
- s_ready  input  1  slave completion
- s_addr  output  32  granted master address
- s_wdata  output  32  granted master write data
- s_wstrb  output  4  granted master strobes
- s_rdata  input  32  slave read data
- grant  output  2  one-hot current owner; 00 = idle
- timeout_err  output  1  sticky flag, set on forced completion

Behaviour:
- State machine: IDLE, GNT0, GNT1, plus ERR when the optional feature is compiled in. State and last_owner are registered.
- Reset (synchronous, at the clk edge while reset=1):
  - state=IDLE, last_owner=1 (so master 0 wins the first tie), timeout counter=0, timeout_err=0.
  - Every output is 0 in the cycle after the edge: s_valid, m0_ready, m1_ready, grant; s_addr/s_wdata/s_wstrb=0; m0_rdata/m1_rdata=0.
- IDLE:
  - Only m0_valid -> GNT0. Only m1_valid -> GNT1.
  - Both -> the master not equal to last_owner. Neither -> stay in IDLE.
  - s_valid=0 and grant=00 while in IDLE.
- GNTx:
  - s_valid=1; s_addr/s_wdata/s_wstrb = mx_*; grant bit x set.
  - mx_ready = s_ready, mx_rdata = s_rdata (combinational, same cycle). The non-granted master sees ready=0, rdata=0.
  - On s_ready: last_owner<=x, next state IDLE.
- Latency:
  - Request seen in IDLE at cycle N -> s_valid at N+1.
  - Zero added cycles on the return path.
  - One mandatory IDLE cycle after every completion. This guarantees the master's valid has dropped before re-arbitration, so no transfer is issued twice.
- Fairness: while both masters request continuously, grants alternate 0,1,0,1. Neither master waits more than one foreign transfer.
- Masters must hold addr/wdata/wstrb stable while valid. The arbiter does not register them.
- Requests asserted during GNTx by the other master are not lost: valid stays high and is arbitrated in the next IDLE.
- A master dropping valid before ready is illegal. Behaviour is undefined; no recovery is required.
- Reset mid-transfer: the grant is abandoned at the reset edge and s_valid drops in the next cycle. A slave completion in that same cycle is not forwarded.

Optional Feature:
- Macro: PICOSOC_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to GNTx and increments each GNTx cycle while s_ready=0.
  - When it reaches TIMEOUT_CYCLES (s_ready still 0) -> ERR for one cycle. In ERR: s_valid=0, mx_ready=1 for the stalled owner, mx_rdata=ERR_RDATA, timeout_err<=1.
  - ERR -> IDLE, with last_owner<=x.
  - s_ready in the same cycle the count hits the limit takes precedence: normal completion.
  - timeout_err stays set until reset.
- Without the macro: no counter and no ERR state; GNTx waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Reset, then m0 read addr 0x0000_0010, slave returns 0x1234_5678 after 2 cycles -> s_valid one cycle after m0_valid; m0_rdata=0x1234_5678 with m0_ready; grant=01; m1_ready stays 0.
- m0 and m1 assert valid in the same cycle, each slave ack 1 cycle -> grant sequence 01,00,10,00; s_addr follows each owner; each ready pulses exactly once.
- Both masters hold continuous back-to-back requests for 8 transfers -> grants strictly alternate; 4 completions each; one IDLE cycle between consecutive grants.
- m1 write wstrb=4'b0011, wdata=0xAABB_CCDD; m0 raises valid mid-transfer -> s_wstrb=0011 and s_wdata=0xAABB_CCDD unchanged until s_ready; m0 granted after the IDLE cycle.
- Assert reset while in GNT1 with s_ready=1 in that same cycle -> m1_ready not pulsed after the edge; s_valid=0, grant=00; first post-reset tie granted to m0.
- With PICOSOC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never readies -> m0_ready pulses 4 cycles after s_valid rose; m0_rdata=0xFFFF_FFFF; timeout_err=1 until reset. Without the macro -> s_valid stays high, timeout_err=0.

Source files
------------

// File: rtl/picosoc_bus_arbiter.sv
// picosoc_bus_arbiter: two-master round-robin arbiter for the PicoRV32 native memory bus.
// Latency: request seen in IDLE -> s_valid next cycle; return path is combinational (0 cycles); one IDLE cycle follows every completion.
// Backpressure: masters hold valid until granted; a stalled slave holds the grant (or, with the watchdog, gets a forced completion).
//
// Ports: clk/reset (synchronous, active-high); m0_*/m1_* PicoRV32 master buses;
//        s_* slave bus (pass-through of the granted master); grant = one-hot owner; timeout_err = sticky watchdog flag.
// Optional macro: PICOSOC_ARB_TIMEOUT_EN adds the hung-transfer watchdog and the ERR state.
module picosoc_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
`ifdef PICOSOC_ARB_TIMEOUT_EN
    , ERR = 2'd3
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_owner;  // master that completed last; the other one wins a tie
  logic        w_own;         // owner of the current grant (0/1)
  logic        w_done;        // owner's transfer completes this cycle
  logic        w_fwd_rdy;     // completion to forward to the owner
  logic [31:0] w_fwd_dat;     // read data to forward to the owner

`ifdef PICOSOC_ARB_TIMEOUT_EN
  // The count reaches TIMEOUT_CYCLES on the stall cycle where r_cnt == LIMIT.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_err_owner;
  logic        r_timeout_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_own       = 1'b0;
    w_done      = 1'b0;
    w_fwd_rdy   = 1'b0;
    w_fwd_dat   = '0;
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    grant       = 2'b00;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;

    case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) w_state_nxt = r_last_owner ? GNT0 : GNT1;
        else if (m0_valid)        w_state_nxt = GNT0;
        else if (m1_valid)        w_state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        w_own     = (r_state == GNT1);
        grant     = w_own ? 2'b10 : 2'b01;
        s_valid   = 1'b1;
        s_addr    = w_own ? m1_addr  : m0_addr;
        s_wdata   = w_own ? m1_wdata : m0_wdata;
        s_wstrb   = w_own ? m1_wstrb : m0_wstrb;
        w_fwd_rdy = s_ready;
        w_fwd_dat = s_rdata;
        if (s_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef PICOSOC_ARB_TIMEOUT_EN
        else if (r_cnt == LIMIT) begin
          w_state_nxt = ERR;
        end
`endif
      end
`ifdef PICOSOC_ARB_TIMEOUT_EN
      ERR: begin
        // Slave is dropped (s_valid=0); the stalled master gets an error completion.
        w_own       = r_err_owner;
        grant       = w_own ? 2'b10 : 2'b01;
        w_fwd_rdy   = 1'b1;
        w_fwd_dat   = ERR_RDATA;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase

    // A completion arriving while reset is asserted belongs to an abandoned grant.
    if (!reset) begin
      m0_ready = grant[0] & w_fwd_rdy;
      m1_ready = grant[1] & w_fwd_rdy;
      m0_rdata = grant[0] ? w_fwd_dat : '0;
      m1_rdata = grant[1] ? w_fwd_dat : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_done) r_last_owner <= w_own;
    end
  end

`ifdef PICOSOC_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_err_owner   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Held at zero in IDLE, so every grant starts counting from zero.
      if (r_state == IDLE)                                 r_cnt <= '0;
      else if ((r_state == GNT0 || r_state == GNT1) && !s_ready) r_cnt <= r_cnt + 16'd1;
      if (w_state_nxt == ERR) r_err_owner   <= w_own;
      if (r_state == ERR)     r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  // Watchdog parameters only matter when the watchdog is built in.
  logic w_unused_params;
  assign w_unused_params = ^{ERR_RDATA, 16'(TIMEOUT_CYCLES)};
  assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
module tb_picosoc_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
  logic        s_valid, s_ready, timeout_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  picosoc_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, v0, v1, sr;
    logic [31:0] srd;
    logic [1:0]  g;
    logic        r0, r1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic v0, input logic v1, input logic sr,
                              input logic [31:0] srd, input logic [1:0] g,
                              input logic r0, input logic r1);
    vec_t r;
    r.rst = rst; r.v0 = v0; r.v1 = v1; r.sr = sr; r.srd = srd; r.g = g; r.r0 = r0; r.r1 = r1;
    vecs.push_back(r);
  endfunction

  // Random-phase state
  logic        v[2];
  logic [31:0] fa[2], fd[2];
  logic [3:0]  fs[2];
  int          gap[2], issued[2], done[2], waits[2], maxw[2];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ea, ed, r0d, r1d;
    logic [3:0]  es;
    logic [1:0]  eg, pg;
    logic        psr, first;
    logic        pv[2];
    int          last, gidx, lat;

    reset = 1'b1;
    m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = '0;
    m0_addr = 32'h10; m0_wdata = 32'h0101_0101; m0_wstrb = 4'h0;
    m1_addr = 32'h20; m1_wdata = 32'h0202_0202; m1_wstrb = 4'hF;
    repeat (3) next_cycle();

    // ---------------- table-driven directed vectors ----------------
    add(0,0,0,0,32'h0,          2'b00,0,0);  // state right after reset
    // m0 read of 0x10, slave answers 2 cycles after s_valid
    add(0,1,0,0,32'h0,          2'b00,0,0);
    add(0,1,0,0,32'h0,          2'b01,0,0);
    add(0,1,0,0,32'h0,          2'b01,0,0);
    add(0,1,0,1,32'h1234_5678,  2'b01,1,0);
    add(0,0,0,0,32'h0,          2'b00,0,0);
    add(1,0,0,0,32'h0,          2'b00,0,0);  // reset: m0 wins next tie
    // simultaneous requests, 1-cycle acks
    add(0,1,1,0,32'h0,          2'b00,0,0);
    add(0,1,1,1,32'hA0A0_0001,  2'b01,1,0);
    add(0,0,1,0,32'h0,          2'b00,0,0);
    add(0,0,1,1,32'hB0B0_0002,  2'b10,0,1);
    add(0,0,0,0,32'h0,          2'b00,0,0);
    // 8 back-to-back transfers; each master drops valid for the IDLE after its ack
    add(0,1,1,0,32'h0,          2'b00,0,0);
    for (int k = 0; k < 8; k++) begin
      add(0,1,1,1,32'hC000_0000 + 32'(k), (k % 2 == 1) ? 2'b10 : 2'b01, k % 2 == 0, k % 2 == 1);
      add(0,(k % 2 == 1) && (k < 7),(k % 2 == 0) && (k < 7),0,32'h0, 2'b00,0,0);
    end
    // reset while in GNT1 with s_ready=1 in the same cycle
    add(0,0,1,0,32'h0,          2'b00,0,0);
    add(0,0,1,0,32'h0,          2'b10,0,0);
    add(1,0,1,1,32'hDEAD_BEEF,  2'b10,0,0);
    add(0,1,1,0,32'h0,          2'b00,0,0);
    add(0,1,1,0,32'h0,          2'b01,0,0);
    add(0,1,1,1,32'h5555_0001,  2'b01,1,0);
    add(0,0,1,0,32'h0,          2'b00,0,0);
    add(0,0,1,1,32'h5555_0002,  2'b10,0,1);
    add(0,0,0,0,32'h0,          2'b00,0,0);

    foreach (vecs[i]) begin
      next_cycle();
      reset = vecs[i].rst; m0_valid = vecs[i].v0; m1_valid = vecs[i].v1;
      s_ready = vecs[i].sr; s_rdata = vecs[i].srd;
      @(negedge clk);
      eg  = vecs[i].g;
      ea  = eg[0] ? 32'h10 : eg[1] ? 32'h20 : 32'h0;
      ed  = eg[0] ? 32'h0101_0101 : eg[1] ? 32'h0202_0202 : 32'h0;
      es  = eg[1] ? 4'hF : 4'h0;
      r0d = (eg[0] && !vecs[i].rst) ? vecs[i].srd : 32'h0;
      r1d = (eg[1] && !vecs[i].rst) ? vecs[i].srd : 32'h0;
      chk($sformatf("vec%0d", i),
          160'({grant, s_valid, m0_ready, m1_ready, timeout_err, s_addr, s_wdata, s_wstrb,
                vecs[i].rst ? 32'h0 : m0_rdata, vecs[i].rst ? 32'h0 : m1_rdata}),
          160'({eg, |eg, vecs[i].r0, vecs[i].r1, 1'b0, ea, ed, es, r0d, r1d}));
    end

    // ---------------- m1 write, m0 requests mid-transfer ----------------
    next_cycle();
    m1_addr = 32'h40; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011; m1_valid = 1;
    @(negedge clk); chk("wr_idle", 160'(grant), 160'(2'b00));
    next_cycle();
    @(negedge clk); chk("wr_g1", 160'({grant, s_wstrb, s_wdata, s_addr}), 160'({2'b10, 4'b0011, 32'hAABB_CCDD, 32'h40}));
    for (int k = 0; k < 2; k++) begin
      next_cycle(); m0_valid = 1;
      @(negedge clk);
      chk("wr_hold", 160'({grant, s_wstrb, s_wdata, m0_ready, m1_ready}),
          160'({2'b10, 4'b0011, 32'hAABB_CCDD, 1'b0, 1'b0}));
    end
    next_cycle(); s_ready = 1; s_rdata = 32'h0;
    @(negedge clk); chk("wr_done", 160'({m1_ready, m0_ready, grant}), 160'({1'b1, 1'b0, 2'b10}));
    next_cycle(); s_ready = 0; m1_valid = 0;
    @(negedge clk); chk("wr_gap", 160'({grant, s_valid, m0_ready}), 160'({2'b00, 1'b0, 1'b0}));
    next_cycle();
    @(negedge clk); chk("wr_m0g", 160'({grant, s_addr}), 160'({2'b01, 32'h10}));
    next_cycle(); s_ready = 1; s_rdata = 32'h0000_0077;
    @(negedge clk); chk("wr_m0d", 160'({m0_ready, m0_rdata, m1_ready}), 160'({1'b1, 32'h77, 1'b0}));
    next_cycle(); s_ready = 0; m0_valid = 0;
    @(negedge clk); chk("wr_end", 160'(grant), 160'(2'b00));

    // ---------------- hung slave ----------------
    next_cycle(); m0_valid = 1;
    @(negedge clk); chk("to_req", 160'({grant, s_valid}), 160'({2'b00, 1'b0}));
`ifdef PICOSOC_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      next_cycle();
      @(negedge clk); chk($sformatf("to_wait%0d", k), 160'({s_valid, m0_ready, timeout_err}), 160'({1'b1, 1'b0, 1'b0}));
    end
    next_cycle();
    @(negedge clk);
    chk("to_err", 160'({s_valid, m0_ready, m0_rdata, m1_ready}), 160'({1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0}));
    next_cycle(); m0_valid = 0;
    @(negedge clk); chk("to_flag", 160'({timeout_err, s_valid, grant}), 160'({1'b1, 1'b0, 2'b00}));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk); chk("to_sticky", 160'(timeout_err), 160'(1'b1));
    end
`else
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      @(negedge clk); chk($sformatf("to_hold%0d", k), 160'({s_valid, grant, m0_ready, timeout_err}), 160'({1'b1, 2'b01, 1'b0, 1'b0}));
    end
    next_cycle(); s_ready = 1; s_rdata = 32'h0;
    @(negedge clk); chk("to_late", 160'(m0_ready), 160'(1'b1));
    next_cycle(); s_ready = 0; m0_valid = 0;
`endif
    next_cycle(); reset = 1;
    next_cycle(); reset = 0;
    @(negedge clk); chk("to_clear", 160'({timeout_err, grant, s_valid}), 160'({1'b0, 2'b00, 1'b0}));

    // ---------------- randomized traffic vs. reference model ----------------
    next_cycle(); reset = 1;
    first = 1; last = 1; pg = 2'b00; psr = 0; gidx = 0; lat = 0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; gap[i] = 0; issued[i] = 0; done[i] = 0; waits[i] = 0; maxw[i] = 0; pv[i] = 0;
      fa[i] = '0; fd[i] = '0; fs[i] = '0;
    end
    for (int t = 0; t < 640; t++) begin
      next_cycle();
      reset = 0;
      // Expected owner this cycle from last cycle's bus activity.
      if (first)                eg = 2'b00;
      else if (pg != 2'b00)     eg = psr ? 2'b00 : pg;
      else if (pv[0] && pv[1])  eg = (last == 1) ? 2'b01 : 2'b10;
      else if (pv[0])           eg = 2'b01;
      else if (pv[1])           eg = 2'b10;
      else                      eg = 2'b00;
      first = 0;
      for (int i = 0; i < 2; i++) begin
        if (!v[i]) begin
          fa[i] = $urandom; fd[i] = $urandom; fs[i] = 4'($urandom);
          if (gap[i] > 0) gap[i]--;
          else if (t < 600 && $urandom_range(0, 2) != 0) begin
            v[i] = 1; issued[i]++;
          end
        end
      end
      m0_valid = v[0]; m0_addr = fa[0]; m0_wdata = fd[0]; m0_wstrb = fs[0];
      m1_valid = v[1]; m1_addr = fa[1]; m1_wdata = fd[1]; m1_wstrb = fs[1];
      if (s_valid) begin
        s_ready = (gidx == lat);
        gidx++;
      end else begin
        s_ready = 0; gidx = 0; lat = $urandom_range(0, 3);
      end
      s_rdata = $urandom;
      @(negedge clk);
      ea  = eg[0] ? fa[0] : eg[1] ? fa[1] : 32'h0;
      ed  = eg[0] ? fd[0] : eg[1] ? fd[1] : 32'h0;
      es  = eg[0] ? fs[0] : eg[1] ? fs[1] : 4'h0;
      r0d = eg[0] ? s_rdata : 32'h0;
      r1d = eg[1] ? s_rdata : 32'h0;
      chk($sformatf("rand_t%0d", t),
          160'({grant, s_valid, m0_ready, m1_ready, timeout_err, s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata}),
          160'({eg, |eg, eg[0] & s_ready, eg[1] & s_ready, 1'b0, ea, ed, es, r0d, r1d}));
      // A newly started foreign grant costs a waiting master one transfer.
      if (eg != 2'b00 && pg == 2'b00)
        for (int i = 0; i < 2; i++)
          if (v[i] && !eg[i]) begin
            waits[i]++;
            if (waits[i] > maxw[i]) maxw[i] = waits[i];
          end
      pv[0] = v[0]; pv[1] = v[1];
      for (int i = 0; i < 2; i++)
        if (eg[i] && s_ready) begin
          done[i]++; v[i] = 0; gap[i] = $urandom_range(0, 2); waits[i] = 0; last = i;
        end
      pg = eg; psr = s_ready;
    end
    chk("m0_all_done", 160'(done[0]), 160'(issued[0]));
    chk("m1_all_done", 160'(done[1]), 160'(issued[1]));
    chk("m0_fair", 160'(maxw[0] <= 1), 160'(1'b1));
    chk("m1_fair", 160'(maxw[1] <= 1), 160'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
